// File: rtl/not_pipe_if.sv
// Handshake bundle for not_pipe: operand/mode input channel and result output channel.
// valid/ready: a word moves when valid and ready are both high on a rising clk edge.
interface not_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_mask;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_mask, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/not_pipe.sv
// Pipelined Not16-style operand conditioner: selectable pass/invert/masked-xor/invert-and-mask
// followed by STAGES registered slots with full valid/ready backpressure.
module not_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    not_pipe_if.slave        bus,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count
);

    logic [WIDTH-1:0]  op_result;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic              accept;

    always_comb begin
        op_result = bus.in_data;
        case (bus.in_mode)
            2'd0:    op_result = bus.in_data;
            2'd1:    op_result = ~bus.in_data;
            2'd2:    op_result = bus.in_data ^ bus.in_mask;
            default: op_result = ~bus.in_data & bus.in_mask;
        endcase
    end

    // A stage advances if it is empty or anything downstream of it can move.
    // in_ready is therefore combinational from out_ready through the whole chain.
    always_comb begin
        logic room;
        room = bus.out_ready;
        adv  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            room   = room | ~v[i];
            adv[i] = room;
        end
    end

    assign accept        = bus.in_valid & adv[0];
    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign busy          = |v;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] d_in;

        if (g == 0) begin : g_first
            assign v_in = accept;
            assign d_in = op_result;
        end else begin : g_rest
            assign v_in = v[g-1];
            assign d_in = data_q[g-1];
        end

        // Data loads only behind a valid word so idle slots keep their last value.
        always_ff @(posedge clk) begin
            if (reset) begin
                v[g]      <= 1'b0;
                data_q[g] <= '0;
            end else if (adv[g]) begin
                v[g] <= v_in;
                if (v_in) begin
                    data_q[g] <= d_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (accept) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_not_pipe.sv
// Randomized scoreboard bench for not_pipe plus directed latency, backpressure, reset
// and narrow-configuration (WIDTH=1, STAGES=1, CNT_W=4) checks.
module tb_not_pipe;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    always #5 clk = ~clk;

    not_pipe_if #(.WIDTH(W)) bus ();
    not_pipe_if #(.WIDTH(1)) bus2 ();

    logic          busy;
    logic [CW-1:0] xfer_count;
    logic          busy2;
    logic [3:0]    xfer2;

    not_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    not_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(4)) dut2 (
        .clk        (clk),
        .reset      (reset2),
        .bus        (bus2),
        .busy       (busy2),
        .xfer_count (xfer2)
    );

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  exp_q[$];
    int            occ = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data = '0;

    function automatic logic [W-1:0] ref_op(logic [W-1:0] d, logic [W-1:0] m, logic [1:0] md);
        case (md)
            2'd0:    return d;
            2'd1:    return ~d;
            2'd2:    return d ^ m;
            default: return (~d) & m;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; inputs change on the falling edge, handshakes are judged 1ns later.
    task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic [W-1:0] m,
                               input logic [1:0] md, input logic ordy,
                               output logic acc, output logic ov, output logic [W-1:0] od);
        @(negedge clk);
        reset         = 1'b0;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_mask   = m;
        bus.in_mode   = md;
        bus.out_ready = ordy;
        #1;
        check("in_ready", bus.in_ready, ordy || (occ < S));
        check("busy", busy, occ != 0);
        check("xfer_count", xfer_count, exp_cnt);
        acc = v && bus.in_ready;
        ov  = bus.out_valid;
        od  = bus.out_data;
        if (ov && ordy) occ--;
        if (acc) begin
            occ++;
            exp_q.push_back(ref_op(d, m, md));
            exp_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        occ     = 0;
        exp_cnt = '0;
    endtask

    always @(negedge clk) begin
        #2;
        if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", bus.out_data, prev_data);
        end
        if (bus.out_valid && bus.out_ready && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected nothing (t=%0t)", bus.out_data, $time);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready && !reset;
        prev_data  = bus.out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc, ov;
        logic [W-1:0] od;
        logic         obs_v [8];
        logic [W-1:0] obs_d [8];
        logic [W-1:0] t2_exp [4];
        logic [W-1:0] first_res;
        bit           got;

        t2_exp = '{16'hA5A5, 16'h5A5A, 16'hAAAA, 16'h0A0A};
        reset = 1'b1;
        reset2 = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mask = '0; bus.in_mode = 2'd0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = 1'b0; bus2.in_mask = 1'b0; bus2.in_mode = 2'd0; bus2.out_ready = 1'b0;

        // Single invert, latency of S cycles
        do_reset();
        drive_cycle(1'b1, 16'h00FF, 16'h0000, 2'd1, 1'b1, acc, ov, od);
        check("t1_accept", acc, 1'b1);
        check("t1_reset_valid", ov, 1'b0);
        check("t1_reset_data", od, 16'h0000);
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, ov, od);
        check("t1_early_valid", ov, 1'b0);
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, ov, od);
        check("t1_valid", ov, 1'b1);
        check("t1_data", od, 16'hFF00);
        check("t1_count", xfer_count, 16'd1);

        // Back-to-back modes, no bubbles
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(i < 4, 16'hA5A5, 16'h0F0F, 2'(i), 1'b1, acc, ov, od);
            obs_v[i] = ov;
            obs_d[i] = od;
            if (i < 4) check("t2_accept", acc, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", obs_v[i+S], 1'b1);
            check("t2_data", obs_d[i+S], t2_exp[i]);
        end

        // Backpressure fill, then simultaneous accept and emit
        do_reset();
        drive_cycle(1'b1, 16'h1234, 16'h0, 2'd0, 1'b0, acc, ov, od);
        check("t3_acc1", acc, 1'b1);
        first_res = 16'h1234;
        drive_cycle(1'b1, 16'h4321, 16'hFFFF, 2'd2, 1'b0, acc, ov, od);
        check("t3_acc2", acc, 1'b1);
        drive_cycle(1'b1, 16'h0F0F, 16'h00FF, 2'd3, 1'b0, acc, ov, od);
        check("t3_stall3", acc, 1'b0);
        drive_cycle(1'b1, 16'h0F0F, 16'h00FF, 2'd1, 1'b0, acc, ov, od);
        check("t3_stall3b", acc, 1'b0);
        check("t3_held", od, first_res);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            drive_cycle(1'b1, 16'h0F0F, 16'h00FF, 2'd3, 1'b1, acc, ov, od);
            if (k == 0) check("t4_simul_accept", acc, 1'b1);
            got = acc;
        end
        if (!got) check("t3_accept_bound", 1'b0, 1'b1);
        for (int k = 0; k < S + 3; k++) drive_cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, ov, od);
        check("t3_count", xfer_count, 16'd3);
        check("t3_drained", exp_q.size(), 0);

        // Reset with words in flight
        do_reset();
        drive_cycle(1'b1, 16'hBEEF, 16'h0, 2'd1, 1'b0, acc, ov, od);
        drive_cycle(1'b1, 16'hCAFE, 16'h0, 2'd0, 1'b0, acc, ov, od);
        do_reset();
        drive_cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, ov, od);
        check("t5_valid", ov, 1'b0);
        check("t5_data", od, 16'h0000);
        check("t5_busy", busy, 1'b0);
        for (int k = 0; k < 5; k++) drive_cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, ov, od);

        // Randomized traffic with alternating backpressure intensity
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 99) < 70, W'($urandom), W'($urandom),
                        2'($urandom_range(0, 3)),
                        $urandom_range(0, 99) < (((i / 50) % 2) == 1 ? 25 : 85),
                        acc, ov, od);
        end
        for (int k = 0; k < S + 3; k++) drive_cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, ov, od);
        check("rand_drained", exp_q.size(), 0);
        check("rand_count", xfer_count, exp_cnt);

        // Narrow instance: 4-bit counter wrap, single-stage invert, pass-through ready
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        #1;
        check("w1_reset_ready", bus2.in_ready, 1'b1);
        check("w1_reset_count", xfer2, 4'd0);
        check("w1_reset_valid", bus2.out_valid, 1'b0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus2.in_valid  = 1'b1;
            bus2.in_data   = 1'b1;
            bus2.in_mask   = 1'b0;
            bus2.in_mode   = (i == 16) ? 2'd1 : 2'd0;
            bus2.out_ready = 1'b1;
            #1;
            check("w1_in_ready", bus2.in_ready, 1'b1);
            if (i > 0) begin
                check("w1_pass_valid", bus2.out_valid, 1'b1);
                check("w1_pass_data", bus2.out_data, 1'b1);
            end
        end
        @(negedge clk);
        bus2.in_valid  = 1'b1;
        bus2.in_data   = 1'b0;
        bus2.in_mode   = 2'd0;
        bus2.out_ready = 1'b0;
        #1;
        check("w1_invert_valid", bus2.out_valid, 1'b1);
        check("w1_invert_data", bus2.out_data, 1'b0);
        check("w1_wrap", xfer2, 4'd1);
        check("w1_full_stall", bus2.in_ready, 1'b0);
        bus2.out_ready = 1'b1;
        #1;
        check("w1_passthru", bus2.in_ready, 1'b1);
        @(negedge clk);
        bus2.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
